// File: rtl/conv_sched_ctrl.sv
// Sequencer for a K x K systolic convolution: weight load, then per output row clear/feed/drain/write.
// Latency: K*K + OUT_H*(IMG_W+2K+OUT_W) + 1 cycles per run with no stalls; outputs decode registered state.
// Backpressure: y_ready low in WRITE holds j, address and state one cycle per low cycle. CONV_CTRL_PERF_EN adds perf counters.
module conv_sched_ctrl #(
    parameter  int ARR_N  = 3,
    parameter  int IMG_H  = 8,
    parameter  int IMG_W  = 8,
    parameter  int ADDR_W = 8,
    localparam int OUT_H  = IMG_H - ARR_N + 1,
    localparam int OUT_W  = IMG_W - ARR_N + 1,
    localparam int CW     = $clog2(OUT_W)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              y_ready,
    output logic              busy,
    output logic              done,
    output logic [6:0]        state,
    output logic [6:0]        next_state,
    output logic              w_rd_en,
    output logic [ADDR_W-1:0] w_rd_addr,
    output logic              arr_w_load,
    output logic              arr_clr,
    output logic              x_rd_en,
    output logic [ADDR_W-1:0] x_rd_addr,
    output logic              arr_en,
    output logic              arr_x_valid,
    output logic [CW-1:0]     arr_out_sel,
    output logic              y_wr_en,
`ifdef CONV_CTRL_PERF_EN
    output logic [31:0]       perf_cycles,
    output logic [31:0]       perf_stalls,
`endif
    output logic [ADDR_W-1:0] y_wr_addr
);

    typedef enum logic [6:0] {
        IDLE   = 7'b0000001,
        LOAD_W = 7'b0000010,
        CLEAR  = 7'b0000100,
        FEED   = 7'b0001000,
        DRAIN  = 7'b0010000,
        WRITE  = 7'b0100000,
        DONE   = 7'b1000000
    } state_t;

    // Terminal counts for the shared phase counter, and row geometry, in address width.
    localparam logic [ADDR_W-1:0] W_LAST  = ADDR_W'(ARR_N * ARR_N - 1);
    localparam logic [ADDR_W-1:0] F_LAST  = ADDR_W'(IMG_W - 1);
    localparam logic [ADDR_W-1:0] D_LAST  = ADDR_W'(2 * ARR_N - 2);
    localparam logic [ADDR_W-1:0] J_LAST  = ADDR_W'(OUT_W - 1);
    localparam logic [ADDR_W-1:0] R_LAST  = ADDR_W'(OUT_H - 1);
    localparam logic [ADDR_W-1:0] IMG_W_A = ADDR_W'(IMG_W);
    localparam logic [ADDR_W-1:0] OUT_W_A = ADDR_W'(OUT_W);

    state_t            state_q;
    state_t            state_d;
    logic [ADDR_W-1:0] cnt;       // weight index, column c, drain count or output column j
    logic [ADDR_W-1:0] row;       // output row r
    logic              cnt_last;
    logic              cnt_step;

    // Phase counter terminal detect and advance enable for the current state.
    always_comb begin
        cnt_last = 1'b0;
        cnt_step = 1'b0;
        case (state_q)
            LOAD_W: begin cnt_last = (cnt == W_LAST); cnt_step = 1'b1;    end
            FEED:   begin cnt_last = (cnt == F_LAST); cnt_step = 1'b1;    end
            DRAIN:  begin cnt_last = (cnt == D_LAST); cnt_step = 1'b1;    end
            WRITE:  begin cnt_last = (cnt == J_LAST); cnt_step = y_ready; end
            default: ;
        endcase
    end

    // Next-state selection; start is only looked at in IDLE.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start)    state_d = LOAD_W;
            LOAD_W:  if (cnt_last) state_d = CLEAR;
            CLEAR:                 state_d = FEED;
            FEED:    if (cnt_last) state_d = DRAIN;
            DRAIN:   if (cnt_last) state_d = WRITE;
            WRITE:   if (y_ready && cnt_last) state_d = (row == R_LAST) ? DONE : CLEAR;
            DONE:                  state_d = IDLE;
            default:               state_d = IDLE;
        endcase
    end

    // State register, phase/row counters and the one-cycle strobe delays.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            cnt         <= '0;
            row         <= '0;
            arr_w_load  <= 1'b0;
            arr_x_valid <= 1'b0;
        end else begin
            state_q     <= state_d;
            arr_w_load  <= w_rd_en;
            arr_x_valid <= x_rd_en;
            if (state_d != state_q)
                cnt <= '0;
            else if (cnt_step)
                cnt <= cnt + ADDR_W'(1);
            if (state_q == IDLE || state_q == DONE)
                row <= '0;
            else if (state_q == WRITE && state_d == CLEAR)
                row <= row + ADDR_W'(1);
        end
    end

    assign state       = state_q;
    assign next_state  = state_d;
    assign busy        = (state_q != IDLE);
    assign done        = (state_q == DONE);
    assign w_rd_en     = (state_q == LOAD_W);
    assign w_rd_addr   = cnt;
    assign arr_clr     = (state_q == CLEAR);
    assign x_rd_en     = (state_q == FEED);
    assign x_rd_addr   = row * IMG_W_A + cnt;
    assign arr_en      = (state_q == FEED) || (state_q == DRAIN);
    assign arr_out_sel = cnt[CW-1:0];
    assign y_wr_en     = (state_q == WRITE) && y_ready;
    assign y_wr_addr   = row * OUT_W_A + cnt;

`ifdef CONV_CTRL_PERF_EN
    // Busy-cycle and write-stall counters: cleared on launch, held while idle, saturating.
    always_ff @(posedge clk) begin
        if (rst) begin
            perf_cycles <= '0;
            perf_stalls <= '0;
        end else if (state_q == IDLE) begin
            if (start) begin
                perf_cycles <= '0;
                perf_stalls <= '0;
            end
        end else begin
            if (perf_cycles != '1)
                perf_cycles <= perf_cycles + 32'd1;
            if (state_q == WRITE && !y_ready && perf_stalls != '1)
                perf_stalls <= perf_stalls + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_conv_sched_ctrl.sv
module tb_conv_sched_ctrl;

    localparam int ARR_N  = 3;
    localparam int IMG_H  = 8;
    localparam int IMG_W  = 8;
    localparam int ADDR_W = 8;
    localparam int OUT_H  = IMG_H - ARR_N + 1;
    localparam int OUT_W  = IMG_W - ARR_N + 1;
    localparam int CW     = $clog2(OUT_W);
    localparam int NOUT   = OUT_H * OUT_W;

    logic              clk = 1'b0;
    logic              rst, start, y_ready;
    logic              busy, done, w_rd_en, arr_w_load, arr_clr, x_rd_en, arr_en, arr_x_valid, y_wr_en;
    logic [6:0]        state, next_state;
    logic [ADDR_W-1:0] w_rd_addr, x_rd_addr, y_wr_addr;
    logic [CW-1:0]     arr_out_sel;
`ifdef CONV_CTRL_PERF_EN
    logic [31:0]       perf_cycles, perf_stalls;
`endif

    int vectors     = 0;
    int miscompares = 0;
    int edges       = 0;
    int done_cnt    = 0;
    int exp_q[$];

    conv_sched_ctrl #(.ARR_N(ARR_N), .IMG_H(IMG_H), .IMG_W(IMG_W), .ADDR_W(ADDR_W)) dut (
        .clk(clk), .rst(rst), .start(start), .y_ready(y_ready),
        .busy(busy), .done(done), .state(state), .next_state(next_state),
        .w_rd_en(w_rd_en), .w_rd_addr(w_rd_addr), .arr_w_load(arr_w_load), .arr_clr(arr_clr),
        .x_rd_en(x_rd_en), .x_rd_addr(x_rd_addr), .arr_en(arr_en), .arr_x_valid(arr_x_valid),
        .arr_out_sel(arr_out_sel), .y_wr_en(y_wr_en),
`ifdef CONV_CTRL_PERF_EN
        .perf_cycles(perf_cycles), .perf_stalls(perf_stalls),
`endif
        .y_wr_addr(y_wr_addr)
    );

    initial forever #5 clk = ~clk;

    always @(posedge clk) edges <= edges + 1;

    // Scoreboard consumer: every accepted write must match the next queued address.
    task automatic monitor();
        int e;
        logic [ADDR_W-1:0] ea;
        logic [CW-1:0] es;
        forever begin
            @(negedge clk);
            if (done) done_cnt++;
            if (y_wr_en) begin
                vectors++;
                if (exp_q.size() == 0) begin
                    miscompares++;
                    $display("FAIL y_wr_unexpected: got addr %0d, expected no write", y_wr_addr);
                end else begin
                    e  = exp_q.pop_front();
                    ea = ADDR_W'(e);
                    es = CW'(e % OUT_W);
                    if (y_wr_addr !== ea || arr_out_sel !== es) begin
                        miscompares++;
                        $display("FAIL y_wr_addr: got addr %0d sel %0d, expected addr %0d sel %0d",
                                 y_wr_addr, arr_out_sel, ea, es);
                    end
                end
            end
        end
    endtask

    task automatic push_job();
        for (int i = 0; i < NOUT; i++) exp_q.push_back(i);
    endtask

    // Raise start for one sampling edge; e0 is the edge count of that edge.
    task automatic launch(input bit hold, output int e0);
        @(posedge clk); #1;
        start = 1'b1;
        push_job();
        @(posedge clk); #1;
        e0 = edges;
        if (!hold) start = 1'b0;
    endtask

    // Returns at the negedge of the done cycle; lat = edges from start sample to done.
    task automatic wait_done(input int e0, output int lat);
        bit seen = 1'b0;
        lat = -1;
        for (int i = 0; i < 400 && !seen; i++) begin
            @(negedge clk);
            if (done) begin seen = 1'b1; lat = edges - e0; end
        end
        if (!seen) begin
            vectors++; miscompares++;
            $display("FAIL done_timeout: got no done in 400 cycles, expected done");
        end
    endtask

    task automatic wait_state(input logic [6:0] st, input int xaddr, input int yaddr);
        bit seen = 1'b0;
        for (int i = 0; i < 400 && !seen; i++) begin
            @(negedge clk);
            if (state == st && (xaddr < 0 || x_rd_addr == ADDR_W'(xaddr))
                            && (yaddr < 0 || y_wr_addr == ADDR_W'(yaddr))) seen = 1'b1;
        end
        if (!seen) begin
            vectors++; miscompares++;
            $display("FAIL wait_state: got state %b never reached, expected %b", state, st);
        end
    endtask

    task automatic check_end(input string nm, input int lat, input int exp_lat, input int dc0, input int exp_dc);
        vectors++;
        if (lat !== exp_lat) begin
            miscompares++; $display("FAIL %s_latency: got %0d, expected %0d", nm, lat, exp_lat);
        end
        @(negedge clk);
        vectors++;
        if (state !== 7'b0000001 || done !== 1'b0 || busy !== 1'b0) begin
            miscompares++; $display("FAIL %s_return_idle: got state %b done %b, expected 0000001 0", nm, state, done);
        end
        vectors++;
        if (done_cnt - dc0 !== exp_dc) begin
            miscompares++; $display("FAIL %s_done_pulses: got %0d, expected %0d", nm, done_cnt - dc0, exp_dc);
        end
        vectors++;
        if (exp_q.size() !== 0) begin
            miscompares++; $display("FAIL %s_writes_missing: got %0d left, expected 0", nm, exp_q.size());
        end
    endtask

    task automatic check_perf(input string nm, input int cyc, input int stl);
`ifdef CONV_CTRL_PERF_EN
        vectors++;
        if (perf_cycles !== 32'(cyc) || perf_stalls !== 32'(stl)) begin
            miscompares++;
            $display("FAIL %s_perf: got cycles %0d stalls %0d, expected %0d %0d", nm, perf_cycles, perf_stalls, cyc, stl);
        end
`else
        if (cyc < 0 || stl < 0) $display("note %s: negative perf expectation", nm);
`endif
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 1'b0; y_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        repeat (5) @(posedge clk);
        @(negedge clk);
        vectors++;
        if (state !== 7'b0000001 || next_state !== 7'b0000001) begin
            miscompares++; $display("FAIL reset_state: got %b/%b, expected 0000001", state, next_state);
        end
        vectors++;
        if ({w_rd_en, arr_w_load, arr_clr, x_rd_en, arr_en, arr_x_valid, y_wr_en, busy, done} !== 9'b0) begin
            miscompares++;
            $display("FAIL reset_strobes: got %b, expected 000000000",
                     {w_rd_en, arr_w_load, arr_clr, x_rd_en, arr_en, arr_x_valid, y_wr_en, busy, done});
        end
        check_perf("reset", 0, 0);
    endtask

    task automatic test_normal_run();
        int e0, lat, dc0;
        dc0 = done_cnt;
        launch(1'b0, e0);
        for (int k = 0; k < ARR_N * ARR_N; k++) begin
            @(negedge clk);
            vectors++;
            if (w_rd_en !== 1'b1 || w_rd_addr !== ADDR_W'(k) || state !== 7'b0000010) begin
                miscompares++; $display("FAIL load_w: got en %b addr %0d, expected 1 %0d", w_rd_en, w_rd_addr, k);
            end
        end
        @(negedge clk);
        vectors++;
        if (state !== 7'b0000100 || arr_clr !== 1'b1 || arr_w_load !== 1'b1 || next_state !== 7'b0001000) begin
            miscompares++; $display("FAIL clear: got state %b clr %b wload %b, expected 0000100 1 1", state, arr_clr, arr_w_load);
        end
        for (int c = 0; c < IMG_W; c++) begin
            @(negedge clk);
            vectors++;
            if (x_rd_en !== 1'b1 || arr_en !== 1'b1 || x_rd_addr !== ADDR_W'(c)) begin
                miscompares++; $display("FAIL feed: got en %b addr %0d, expected 1 %0d", x_rd_en, x_rd_addr, c);
            end
        end
        @(negedge clk);
        vectors++;
        if (state !== 7'b0010000 || x_rd_en !== 1'b0 || arr_x_valid !== 1'b1 || arr_en !== 1'b1) begin
            miscompares++; $display("FAIL drain: got state %b xen %b xval %b, expected 0010000 0 1", state, x_rd_en, arr_x_valid);
        end
        wait_done(e0, lat);
        check_end("normal", lat, 129, dc0, 1);
        check_perf("normal", 130, 0);
    endtask

    task automatic test_stall();
        int e0, lat, dc0;
        dc0 = done_cnt;
        launch(1'b0, e0);
        wait_state(7'b0100000, -1, OUT_W + 1);
        @(posedge clk); #1 y_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            vectors++;
            if (y_wr_addr !== ADDR_W'(OUT_W + 2) || y_wr_en !== 1'b0 || state !== 7'b0100000) begin
                miscompares++; $display("FAIL stall_hold: got addr %0d en %b, expected %0d 0", y_wr_addr, y_wr_en, OUT_W + 2);
            end
            @(posedge clk);
        end
        #1 y_ready = 1'b1;
        wait_done(e0, lat);
        check_end("stall", lat, 132, dc0, 1);
        check_perf("stall", 133, 3);
    endtask

    task automatic test_ignored_start();
        int e0, lat, dc0;
        dc0 = done_cnt;
        launch(1'b0, e0);
        wait_state(7'b0001000, -1, -1);
        @(posedge clk); #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        wait_done(e0, lat);
        start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        check_end("ignored_start", lat, 129, dc0, 1);
        repeat (2) begin
            @(negedge clk);
            vectors++;
            if (state !== 7'b0000001) begin
                miscompares++; $display("FAIL ignored_start_stays_idle: got %b, expected 0000001", state);
            end
        end
    endtask

    task automatic test_mid_reset();
        int e0, lat, dc0;
        launch(1'b0, e0);
        wait_state(7'b0001000, 3 * IMG_W + 3, -1);
        @(posedge clk); #1 rst = 1'b1;
        @(posedge clk); #1 rst = 1'b0;
        @(negedge clk);
        vectors++;
        if (state !== 7'b0000001 || next_state !== 7'b0000001 ||
            {w_rd_en, arr_w_load, arr_clr, x_rd_en, arr_en, arr_x_valid, y_wr_en, busy, done} !== 9'b0) begin
            miscompares++; $display("FAIL mid_reset_abort: got state %b x_valid %b arr_en %b, expected 0000001 0 0",
                                    state, arr_x_valid, arr_en);
        end
        check_perf("mid_reset", 0, 0);
        exp_q.delete();
        dc0 = done_cnt;
        launch(1'b0, e0);
        @(negedge clk);
        vectors++;
        if (w_rd_addr !== '0 || w_rd_en !== 1'b1) begin
            miscompares++; $display("FAIL mid_reset_restart: got addr %0d en %b, expected 0 1", w_rd_addr, w_rd_en);
        end
        wait_done(e0, lat);
        check_end("mid_reset", lat, 129, dc0, 1);
        check_perf("mid_reset_rerun", 130, 0);
    endtask

    task automatic test_back_to_back();
        int e0, e1, lat, dc0, d0;
        dc0 = done_cnt;
        launch(1'b1, e0);
        wait_done(e0, lat);
        d0 = edges;
        push_job();
        vectors++;
        if (lat !== 129) begin
            miscompares++; $display("FAIL b2b_first_latency: got %0d, expected 129", lat);
        end
        @(negedge clk);
        vectors++;
        if (state !== 7'b0000001 || next_state !== 7'b0000010) begin
            miscompares++; $display("FAIL b2b_idle: got %b next %b, expected 0000001 0000010", state, next_state);
        end
        @(negedge clk);
        e1 = edges;
        vectors++;
        if (state !== 7'b0000010) begin
            miscompares++; $display("FAIL b2b_relaunch: got %b, expected 0000010", state);
        end
        wait_done(e1, lat);
        start = 1'b0;
        vectors++;
        if (edges - d0 !== 131) begin
            miscompares++; $display("FAIL b2b_period: got %0d, expected 131", edges - d0);
        end
        check_end("b2b", lat, 129, dc0, 2);
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; y_ready = 1'b1;
        fork monitor(); join_none
        test_reset();
        test_normal_run();
        test_stall();
        test_ignored_start();
        test_mid_reset();
        test_back_to_back();
        repeat (2) @(posedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
